// File: rtl/ct_ifu_sfp_table.sv
// Store-forward prediction table: tagged entries with confidence counters,
// a registered lowest-index lookup and a round-robin allocation pointer.
//
// Ports:
//   forever_cpuclk, cpurst          clock, synchronous active-high reset
//   cp0_ifu_nsfe, sfp_vl_pred_en    either enables table writes
//   rtu_ifu_chgflw_vld              qualifies the miss-hysteresis rule
//   flush                           clears every counter
//   upd_*                           entry write / counter update request
//   lkp_vld, lkp_hi_pc, lkp_sf_pc   lookup request
//   lkp_hit .. lkp_strong           lookup result, one cycle later
//   alloc_idx                       round-robin victim pointer
//
// Optional feature macro: SFP_MISS_HYST_EN
//   When defined, each entry keeps a miss_state bit. A miss op on an entry
//   with miss_state set, under a change of flow, raises confidence instead
//   of lowering it.
module ct_ifu_sfp_table #(
    parameter int IDX_W   = 3,
    parameter int HI_PC_W = 8,
    parameter int SF_PC_W = 12,
    parameter int CNT_W   = 2
) (
    input  logic               forever_cpuclk,
    input  logic               cpurst,
    input  logic               cp0_ifu_nsfe,
    input  logic               sfp_vl_pred_en,
    input  logic               rtu_ifu_chgflw_vld,
    input  logic               flush,
    input  logic               upd_vld,
    input  logic [IDX_W-1:0]   upd_idx,
    input  logic               upd_sf_pc_updt,
    input  logic               upd_bar_pc_updt,
    input  logic               upd_cnt_updt,
    input  logic [3:0]         upd_op,
    input  logic               upd_type,
    input  logic               upd_miss,
    input  logic [HI_PC_W-1:0] upd_hi_pc,
    input  logic [SF_PC_W-1:0] upd_pc,
    input  logic               lkp_vld,
    input  logic [HI_PC_W-1:0] lkp_hi_pc,
    input  logic [SF_PC_W-1:0] lkp_sf_pc,
    output logic               lkp_hit,
    output logic [IDX_W-1:0]   lkp_hit_idx,
    output logic [SF_PC_W-1:0] lkp_bar_pc,
    output logic               lkp_type,
    output logic               lkp_strong,
    output logic [IDX_W-1:0]   alloc_idx
);

    localparam int ENTRY_NUM = 1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [HI_PC_W-1:0] r_hi_pc  [ENTRY_NUM];
    logic [SF_PC_W-1:0] r_sf_pc  [ENTRY_NUM];
    logic [SF_PC_W-1:0] r_bar_pc [ENTRY_NUM];
    logic               r_type   [ENTRY_NUM];
    logic [CNT_W-1:0]   r_cnt    [ENTRY_NUM];
`ifdef SFP_MISS_HYST_EN
    logic               r_miss   [ENTRY_NUM];
`endif

    logic [IDX_W-1:0]   r_alloc_idx;
    logic               r_lkp_hit;
    logic [IDX_W-1:0]   r_lkp_hit_idx;
    logic [SF_PC_W-1:0] r_lkp_bar_pc;
    logic               r_lkp_type;
    logic               r_lkp_strong;

    logic               w_upd_en;
    logic               w_alloc_adv;
    logic [CNT_W-1:0]   w_cnt_cur;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [CNT_W-1:0]   w_cnt_dec;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_miss_up;
    logic               w_hit;
    logic [IDX_W-1:0]   w_hit_idx;

`ifndef SFP_MISS_HYST_EN
    // Only the hysteresis build consumes these two inputs.
    logic w_unused;
    assign w_unused = upd_miss ^ rtu_ifu_chgflw_vld;
`endif

    assign w_upd_en    = upd_vld && (cp0_ifu_nsfe || sfp_vl_pred_en);
    assign w_alloc_adv = w_upd_en && upd_cnt_updt &&
                         (upd_op == 4'b0010) && (upd_idx == r_alloc_idx);

    // Next counter value for the entry being updated.
    always_comb begin
        w_cnt_cur = r_cnt[upd_idx];
        w_cnt_inc = (w_cnt_cur == CNT_MAX) ? CNT_MAX : w_cnt_cur + CNT_ONE;
        w_cnt_dec = (w_cnt_cur == '0) ? '0 : w_cnt_cur - CNT_ONE;
`ifdef SFP_MISS_HYST_EN
        w_miss_up = r_miss[upd_idx] && rtu_ifu_chgflw_vld;
`else
        w_miss_up = 1'b0;
`endif
        case (upd_op)
            4'b1000: w_cnt_nxt = '0;
            // A typed entry that hits at its first level is retired.
            4'b0100: w_cnt_nxt = (r_type[upd_idx] && w_cnt_cur == CNT_ONE)
                                 ? '0 : w_cnt_inc;
            4'b0010: w_cnt_nxt = CNT_ONE;
            4'b0001: w_cnt_nxt = w_miss_up ? w_cnt_inc : w_cnt_dec;
            default: w_cnt_nxt = '0;
        endcase
    end

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (lkp_vld && (r_cnt[i] != '0) &&
                (r_hi_pc[i] == lkp_hi_pc) && (r_sf_pc[i] == lkp_sf_pc)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                r_hi_pc[i]  <= '0;
                r_sf_pc[i]  <= '0;
                r_bar_pc[i] <= '0;
                r_type[i]   <= 1'b0;
                r_cnt[i]    <= '0;
`ifdef SFP_MISS_HYST_EN
                r_miss[i]   <= 1'b0;
`endif
            end
        end else begin
            if (w_upd_en && upd_sf_pc_updt) begin
                r_hi_pc[upd_idx] <= upd_hi_pc;
                r_sf_pc[upd_idx] <= upd_pc;
                r_type[upd_idx]  <= upd_type;
`ifdef SFP_MISS_HYST_EN
                r_miss[upd_idx]  <= upd_type && upd_miss;
`endif
            end
            if (w_upd_en && upd_bar_pc_updt) begin
                r_bar_pc[upd_idx] <= upd_pc;
            end
            // Flush wins over a counter update but not over tag writes.
            if (flush) begin
                for (int i = 0; i < ENTRY_NUM; i++) begin
                    r_cnt[i] <= '0;
                end
            end else if (w_upd_en && upd_cnt_updt) begin
                r_cnt[upd_idx] <= w_cnt_nxt;
            end
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_alloc_idx <= '0;
        end else if (w_alloc_adv) begin
            r_alloc_idx <= r_alloc_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_lkp_hit     <= 1'b0;
            r_lkp_hit_idx <= '0;
            r_lkp_bar_pc  <= '0;
            r_lkp_type    <= 1'b0;
            r_lkp_strong  <= 1'b0;
        end else if (w_hit) begin
            r_lkp_hit     <= 1'b1;
            r_lkp_hit_idx <= w_hit_idx;
            r_lkp_bar_pc  <= r_bar_pc[w_hit_idx];
            r_lkp_type    <= r_type[w_hit_idx];
            r_lkp_strong  <= (r_cnt[w_hit_idx] == CNT_MAX);
        end else begin
            r_lkp_hit     <= 1'b0;
            r_lkp_hit_idx <= '0;
            r_lkp_bar_pc  <= '0;
            r_lkp_type    <= 1'b0;
            r_lkp_strong  <= 1'b0;
        end
    end

    assign lkp_hit     = r_lkp_hit;
    assign lkp_hit_idx = r_lkp_hit_idx;
    assign lkp_bar_pc  = r_lkp_bar_pc;
    assign lkp_type    = r_lkp_type;
    assign lkp_strong  = r_lkp_strong;
    assign alloc_idx   = r_alloc_idx;

endmodule
